// File: rtl/beam_threshold_sequencer.sv
// Shadow threshold RAM per beam; a commit walks all beams onto thresh/thresh_ce, settles, then strobes update.
// Latency: beam k loads 2+k cycles after commit, update at 2+NBEAMS+SETTLE_CYCLES, done one cycle later.
// Backpressure: wr_ready_o low outside IDLE; commits while busy collapse into one pending rerun. Option: BEAM_THRESH_MASK_EN.
module beam_threshold_sequencer #(
    parameter int NBEAMS        = 46,
    parameter int SETTLE_CYCLES = 2,
    localparam int AW           = $clog2(NBEAMS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [17:0]       wr_data_i,
    input  logic              wr_valid_i,
    output logic              wr_ready_o,
    input  logic              commit_i,
`ifdef BEAM_THRESH_MASK_EN
    input  logic [NBEAMS-1:0] beam_mask_i,
`endif
    output logic              busy_o,
    output logic              done_o,
    output logic [7:0]        commit_count_o,
    output logic [17:0]       thresh_o,
    output logic [NBEAMS-1:0] thresh_ce_o,
    output logic              update_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME,
        S_LOAD,
        S_SETTLE,
        S_UPDATE,
        S_DONE
    } state_t;

    localparam logic [3:0]    SETTLE_LAST = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;
    localparam logic [AW-1:0] LAST_BEAM   = AW'(NBEAMS - 1);

    logic [17:0]       r_ram [NBEAMS];
    state_t            r_state;
    logic [AW-1:0]     r_k;
    logic [3:0]        r_settle;
    logic              r_pending;
    logic              r_wr_rdy;
    logic              r_busy;
    logic              r_done;
    logic              r_update;
    logic [7:0]        r_count;
    logic [17:0]       r_thresh;
    logic [NBEAMS-1:0] r_ce;

    logic              w_addr_ok;
    logic              w_wr_en;
    logic [AW-1:0]     w_next_k;
    logic [17:0]       w_thresh;

    assign w_addr_ok = (int'(wr_addr_i) < NBEAMS);
    assign w_wr_en   = wr_valid_i && r_wr_rdy && w_addr_ok;
    assign w_next_k  = r_k + AW'(1);

    // The mask is applied on the output side so it is sampled in the beam's own LOAD cycle.
`ifdef BEAM_THRESH_MASK_EN
    assign w_thresh = ((r_state == S_LOAD) && beam_mask_i[r_k]) ? 18'h3FFFF : r_thresh;
`else
    assign w_thresh = r_thresh;
`endif

    always_ff @(posedge clk_i) begin
        if (w_wr_en) begin
            r_ram[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_k       <= '0;
            r_settle  <= '0;
            r_pending <= 1'b0;
            r_wr_rdy  <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_update  <= 1'b0;
            r_count   <= '0;
            r_thresh  <= '0;
            r_ce      <= '0;
        end else begin
            r_update <= 1'b0;
            r_done   <= 1'b0;
            if (commit_i && (r_state != S_IDLE)) begin
                r_pending <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (commit_i || r_pending) begin
                        r_state   <= S_PRIME;
                        r_pending <= 1'b0;
                        r_k       <= '0;
                        r_busy    <= 1'b1;
                        r_wr_rdy  <= 1'b0;
                    end
                end
                S_PRIME: begin
                    r_state  <= S_LOAD;
                    r_thresh <= r_ram[0];
                    r_ce     <= NBEAMS'(1);
                end
                S_LOAD: begin
                    if (r_k == LAST_BEAM) begin
                        r_ce     <= '0;
                        r_thresh <= w_thresh;
                        if (SETTLE_CYCLES == 0) begin
                            r_state  <= S_UPDATE;
                            r_update <= 1'b1;
                        end else begin
                            r_state  <= S_SETTLE;
                            r_settle <= '0;
                        end
                    end else begin
                        r_k      <= w_next_k;
                        r_ce     <= r_ce << 1;
                        r_thresh <= r_ram[w_next_k];
                    end
                end
                S_SETTLE: begin
                    if (r_settle == SETTLE_LAST) begin
                        r_state  <= S_UPDATE;
                        r_update <= 1'b1;
                    end else begin
                        r_settle <= r_settle + 4'd1;
                    end
                end
                S_UPDATE: begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_count <= r_count + 8'd1;
                end
                S_DONE: begin
                    r_state  <= S_IDLE;
                    r_wr_rdy <= 1'b1;
                    r_thresh <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign wr_ready_o     = r_wr_rdy;
    assign busy_o         = r_busy;
    assign done_o         = r_done;
    assign commit_count_o = r_count;
    assign thresh_o       = w_thresh;
    assign thresh_ce_o    = r_ce;
    assign update_o       = r_update;

endmodule

// File: tb/tb_beam_threshold_sequencer.sv
// Directed bench: two sequencers (5 beams, settle 2 and settle 0) against hand-computed cycle traces.
module tb_beam_threshold_sequencer;

    localparam int NB = 5;
    localparam int AW = $clog2(NB);

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] wr_addr;
    logic [17:0]   wr_data;
    logic          wr_valid;
    logic          commit;
    logic          commit_b;
    logic [NB-1:0] mask;

    logic          a_rdy, a_busy, a_done, a_upd;
    logic [7:0]    a_cnt;
    logic [17:0]   a_th;
    logic [NB-1:0] a_ce;
    logic          b_rdy, b_busy, b_done, b_upd;
    logic [7:0]    b_cnt;
    logic [17:0]   b_th;
    logic [NB-1:0] b_ce;

    int checks = 0;
    int errors = 0;
    logic [17:0] exp_ram [NB];
    int exp_count = 0;

    always #5 clk = ~clk;

    beam_threshold_sequencer #(.NBEAMS(NB), .SETTLE_CYCLES(2)) dut_a (
        .clk_i(clk), .rst_i(rst), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .wr_valid_i(wr_valid), .wr_ready_o(a_rdy), .commit_i(commit),
`ifdef BEAM_THRESH_MASK_EN
        .beam_mask_i(mask),
`endif
        .busy_o(a_busy), .done_o(a_done), .commit_count_o(a_cnt),
        .thresh_o(a_th), .thresh_ce_o(a_ce), .update_o(a_upd)
    );

    beam_threshold_sequencer #(.NBEAMS(NB), .SETTLE_CYCLES(0)) dut_b (
        .clk_i(clk), .rst_i(rst), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .wr_valid_i(wr_valid), .wr_ready_o(b_rdy), .commit_i(commit_b),
`ifdef BEAM_THRESH_MASK_EN
        .beam_mask_i(mask),
`endif
        .busy_o(b_busy), .done_o(b_done), .commit_count_o(b_cnt),
        .thresh_o(b_th), .thresh_ce_o(b_ce), .update_o(b_upd)
    );

    typedef struct {
        int          cyc;
        logic [NB-1:0] ce;
        logic [17:0] th;
        logic        upd;
        logic        done;
        logic        busy;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input logic [17:0] data);
        wr_addr  = addr;
        wr_data  = data;
        wr_valid = 1'b1;
        chk($sformatf("wr_ready@addr%0d", addr), a_rdy, 1);
        step();
        wr_valid = 1'b0;
    endtask

    function automatic logic [17:0] beam_val(input int k, input logic [NB-1:0] m);
        return m[k] ? 18'h3FFFF : exp_ram[k];
    endfunction

    // Full commit trace from cycle 0 (commit pulse) through cycle 11 (back in IDLE).
    task automatic run_commit(input bit use_b, input logic [NB-1:0] m);
        logic [NB-1:0] e_ce;
        logic [17:0]   e_th;
        logic [17:0]   e_thb;
        mask     = m;
        commit   = 1'b1;
        commit_b = use_b;
        step();
        commit   = 1'b0;
        commit_b = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            e_ce  = (c >= 2 && c <= 6) ? NB'(1 << (c - 2)) : '0;
            e_th  = (c < 2 || c > 10) ? 18'd0 : (c <= 6) ? beam_val(c - 2, m) : beam_val(NB - 1, m);
            e_thb = (c < 2 || c > 8)  ? 18'd0 : (c <= 6) ? beam_val(c - 2, m) : beam_val(NB - 1, m);
            chk($sformatf("ce@%0d", c),     a_ce,   e_ce);
            chk($sformatf("thresh@%0d", c), a_th,   e_th);
            chk($sformatf("update@%0d", c), a_upd,  (c == 9));
            chk($sformatf("done@%0d", c),   a_done, (c == 10));
            chk($sformatf("busy@%0d", c),   a_busy, (c >= 1 && c <= 9));
            if (c == 10) chk("count", a_cnt, 8'(exp_count + 1));
            if (use_b) begin
                chk($sformatf("b_ce@%0d", c),     b_ce,   e_ce);
                chk($sformatf("b_thresh@%0d", c), b_th,   e_thb);
                chk($sformatf("b_update@%0d", c), b_upd,  (c == 7));
                chk($sformatf("b_done@%0d", c),   b_done, (c == 8));
            end
            step();
        end
        exp_count++;
        mask = '0;
    endtask

    initial begin
        vec_t tbl [11];
        int   cyc;
        int   n_upd;
        int   n_done;
        logic busy11;
        logic busy12;

        tbl[0]  = '{1,  5'b00000, 18'd0,   1'b0, 1'b0, 1'b1};
        tbl[1]  = '{2,  5'b00001, 18'd100, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{3,  5'b00010, 18'd200, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{4,  5'b00100, 18'd300, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{5,  5'b01000, 18'd400, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{6,  5'b10000, 18'd500, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{7,  5'b00000, 18'd500, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{8,  5'b00000, 18'd500, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{9,  5'b00000, 18'd500, 1'b1, 1'b0, 1'b1};
        tbl[9]  = '{10, 5'b00000, 18'd500, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{11, 5'b00000, 18'd0,   1'b0, 1'b0, 1'b0};

        rst = 1'b1; wr_addr = '0; wr_data = '0; wr_valid = 1'b0;
        commit = 1'b0; commit_b = 1'b0; mask = '0;
        repeat (3) step();
        chk("rst_wr_ready", a_rdy,  1);
        chk("rst_busy",     a_busy, 0);
        chk("rst_done",     a_done, 0);
        chk("rst_thresh",   a_th,   0);
        chk("rst_ce",       a_ce,   0);
        chk("rst_update",   a_upd,  0);
        chk("rst_count",    a_cnt,  0);
        rst = 1'b0;
        step();

        // Basic commit, literal trace table
        for (int k = 0; k < NB; k++) begin
            exp_ram[k] = 18'((k + 1) * 100);
            do_write(AW'(k), exp_ram[k]);
        end
        commit = 1'b1;
        step();
        commit = 1'b0;
        for (int i = 0; i < 11; i++) begin
            chk($sformatf("t1_ce@%0d", tbl[i].cyc),     a_ce,   tbl[i].ce);
            chk($sformatf("t1_thresh@%0d", tbl[i].cyc), a_th,   tbl[i].th);
            chk($sformatf("t1_update@%0d", tbl[i].cyc), a_upd,  tbl[i].upd);
            chk($sformatf("t1_done@%0d", tbl[i].cyc),   a_done, tbl[i].done);
            chk($sformatf("t1_busy@%0d", tbl[i].cyc),   a_busy, tbl[i].busy);
            step();
        end
        exp_count = 1;
        chk("t1_count", a_cnt, 1);

        // Write held during a commit stalls until IDLE, then is visible to the next commit
        commit = 1'b1;
        step();
        commit = 1'b0;
        step();
        step();
        wr_addr = AW'(1); wr_data = 18'd777; wr_valid = 1'b1;
        cyc = 3;
        chk("t2_rdy_low@3", a_rdy, 0);
        while (!a_rdy && cyc < 30) begin
            step();
            cyc++;
        end
        chk("t2_first_ready_cycle", cyc, 11);
        step();
        wr_valid = 1'b0;
        exp_ram[1] = 18'd777;
        exp_count = 2;
        run_commit(1'b0, '0);

        // Three commits while busy collapse into one rerun
        commit = 1'b1;
        step();
        commit = 1'b0;
        n_upd = 0; n_done = 0; busy11 = 1'b1; busy12 = 1'b0;
        for (int c = 1; c <= 35; c++) begin
            if (a_upd)  n_upd++;
            if (a_done) n_done++;
            if (c == 11) busy11 = a_busy;
            if (c == 12) busy12 = a_busy;
            commit = (c == 3 || c == 5 || c == 7);
            step();
        end
        commit = 1'b0;
        chk("t3_updates", n_upd, 2);
        chk("t3_dones", n_done, 2);
        chk("t3_idle_gap", busy11, 0);
        chk("t3_rerun_start", busy12, 1);
        exp_count += 2;
        chk("t3_count", a_cnt, 8'(exp_count));

        // Reset mid-sequence, with a pending request outstanding
        commit = 1'b1;
        step();
        commit = 1'b0;
        step();
        commit = 1'b1;
        step();
        commit = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t4_ce",     a_ce,   0);
        chk("t4_busy",   a_busy, 0);
        chk("t4_count",  a_cnt,  0);
        chk("t4_thresh", a_th,   0);
        chk("t4_update", a_upd,  0);
        chk("t4_ready",  a_rdy,  1);
        n_upd = 0;
        cyc = 0;
        for (int c = 0; c < 20; c++) begin
            if (a_upd)  n_upd++;
            if (a_busy) cyc++;
            step();
        end
        chk("t4_no_update", n_upd, 0);
        chk("t4_pending_cleared", cyc, 0);
        exp_count = 0;

        // Out-of-range writes are accepted and dropped; settle-0 instance checked alongside
        do_write(AW'(5), 18'd999);
        do_write(AW'(7), 18'd999);
        run_commit(1'b1, '0);
        chk("t5_count", a_cnt, 1);

`ifdef BEAM_THRESH_MASK_EN
        run_commit(1'b1, 5'b00100);
        run_commit(1'b0, 5'b10000);
        run_commit(1'b0, '0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1);
    end

endmodule
